password_checker: RTL and testbench

//  Consumes the set/guess nibbles and enables produced by the input selector. Stores the

---
 rtl/pwlock_pkg.sv | 30 +++
 rtl/enter_sync_edge.sv | 27 ++
 rtl/password_checker.sv | 138 +++++++++++++
 tb/tb_password_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pwlock_pkg.sv
// Shared types for the password lock: FSM states, default code width and enter-mode decode.
package pwlock_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        OPEN,
        LOCKOUT
    } state_e;

    typedef enum logic [1:0] {
        MODE_NONE,
        MODE_SET,
        MODE_GUESS
    } mode_e;

    // Exactly one selector enable must be high for an enter event to mean anything.
    function automatic mode_e decode_mode(input logic set_en, input logic guess_en);
        mode_e mode;
        case ({set_en, guess_en})
            2'b10:   mode = MODE_SET;
            2'b01:   mode = MODE_GUESS;
            default: mode = MODE_NONE;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/enter_sync_edge.sv
// Two-flop synchroniser plus rising-edge detect for an asynchronous pushbutton.
module enter_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic enter_i,
    output logic enter_pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= enter_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign enter_pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/password_checker.sv
// Password lock FSM with attempt counter. Define PWCHK_LOCKOUT_EN to build the timed
// lockout after MAX_ATTEMPTS wrong guesses; without it guessing is unlimited.
module password_checker
    import pwlock_pkg::*;
#(
    parameter  int WIDTH          = DEFAULT_WIDTH,
    parameter  int MAX_ATTEMPTS   = 3,
    parameter  int LOCKOUT_CYCLES = 50_000_000,
    localparam int AW             = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] set_code,
    input  logic [WIDTH-1:0] guess_code,
    input  logic             set_en,
    input  logic             guess_en,
    input  logic             enter,
    output logic             unlocked,
    output logic             locked_out,
    output logic             wrong,
    output logic             armed,
    output logic [AW-1:0]    attempts_left
);

    logic             enter_pulse;
    mode_e            mode;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] pw_q, pw_d;
    logic [AW-1:0]    att_q, att_d;
    logic             wrong_q, wrong_d;

    enter_sync_edge u_enter_sync (
        .clk           (clk),
        .reset         (reset),
        .enter_i       (enter),
        .enter_pulse_o (enter_pulse)
    );

    assign mode = enter_pulse ? decode_mode(set_en, guess_en) : MODE_NONE;

`ifdef PWCHK_LOCKOUT_EN
    localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_lockout_cfg;
    assign unused_lockout_cfg = (LOCKOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pw_q    <= '0;
            att_q   <= AW'(MAX_ATTEMPTS);
            wrong_q <= 1'b0;
`ifdef PWCHK_LOCKOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            att_q   <= att_d;
            wrong_q <= wrong_d;
`ifdef PWCHK_LOCKOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        att_d   = att_q;
        wrong_d = 1'b0;
`ifdef PWCHK_LOCKOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mode == MODE_SET) begin
                    pw_d    = set_code;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (mode == MODE_GUESS) begin
                    if (guess_code == pw_q) begin
                        state_d = OPEN;
                        att_d   = AW'(MAX_ATTEMPTS);
                    end else begin
                        wrong_d = 1'b1;
`ifdef PWCHK_LOCKOUT_EN
                        if (att_q != '0) begin
                            att_d = att_q - AW'(1);
                        end
                        // The last allowed attempt just failed: start the timed lockout.
                        if (att_q <= AW'(1)) begin
                            state_d = LOCKOUT;
                            cnt_d   = '0;
                        end
`endif
                    end
                end
            end
            OPEN: begin
                if (mode == MODE_SET) begin
                    pw_d    = set_code;
                    state_d = ARMED;
                end else if (mode == MODE_GUESS) begin
                    state_d = ARMED;
                end
            end
            LOCKOUT: begin
`ifdef PWCHK_LOCKOUT_EN
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = ARMED;
                    att_d   = AW'(MAX_ATTEMPTS);
                    cnt_d   = '0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign unlocked      = (state_q == OPEN);
    assign armed         = (state_q == ARMED);
    assign wrong         = wrong_q;
    assign attempts_left = att_q;
`ifdef PWCHK_LOCKOUT_EN
    assign locked_out    = (state_q == LOCKOUT);
`else
    assign locked_out    = 1'b0;
`endif

endmodule

// File: tb/tb_password_checker.sv
// Directed self-checking bench for password_checker (MAX_ATTEMPTS=3, LOCKOUT_CYCLES=8);
// expectations follow the build's PWCHK_LOCKOUT_EN setting.
module tb_password_checker;

    localparam int WIDTH = 4;
    localparam int AW    = 2;
`ifdef PWCHK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] set_code;
    logic [WIDTH-1:0] guess_code;
    logic             set_en;
    logic             guess_en;
    logic             enter;
    logic             unlocked;
    logic             locked_out;
    logic             wrong;
    logic             armed;
    logic [AW-1:0]    attempts_left;

    int checks   = 0;
    int failures = 0;

    password_checker #(
        .WIDTH          (WIDTH),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .set_code      (set_code),
        .guess_code    (guess_code),
        .set_en        (set_en),
        .guess_en      (guess_en),
        .enter         (enter),
        .unlocked      (unlocked),
        .locked_out    (locked_out),
        .wrong         (wrong),
        .armed         (armed),
        .attempts_left (attempts_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One press: the FSM has acted when this returns, so outputs reflect the event.
    task automatic applyStimulus();
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
        tick(2);
    endtask

    task automatic checkOutput(input string tag, input logic eU, input logic eL,
                               input logic eW, input logic eA, input logic [AW-1:0] eAtt);
        checks++;
        assert (unlocked === eU) else begin
            failures++;
            $error("[TB] FAIL %s.unlocked observed=%0b expected=%0b", tag, unlocked, eU);
        end
        checks++;
        assert (locked_out === eL) else begin
            failures++;
            $error("[TB] FAIL %s.locked_out observed=%0b expected=%0b", tag, locked_out, eL);
        end
        checks++;
        assert (wrong === eW) else begin
            failures++;
            $error("[TB] FAIL %s.wrong observed=%0b expected=%0b", tag, wrong, eW);
        end
        checks++;
        assert (armed === eA) else begin
            failures++;
            $error("[TB] FAIL %s.armed observed=%0b expected=%0b", tag, armed, eA);
        end
        checks++;
        assert (attempts_left === eAtt) else begin
            failures++;
            $error("[TB] FAIL %s.attempts_left observed=%0d expected=%0d", tag, attempts_left, eAtt);
        end
    endtask

    initial begin
        reset      = 1'b1;
        set_code   = '0;
        guess_code = '0;
        set_en     = 1'b0;
        guess_en   = 1'b0;
        enter      = 1'b0;
        tick(2);
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        reset = 1'b0;
        tick(1);

        $display("[TB] step 1: store password 0xA");
        set_en   = 1'b1;
        set_code = 4'hA;
        enter    = 1'b1;
        tick(1);
        enter = 1'b0;
        tick(1);
        checkOutput("t1_one_edge", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        tick(1);
        checkOutput("t1_armed", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        set_en = 1'b0;

        $display("[TB] step 2: correct guess opens, next guess relocks");
        guess_en   = 1'b1;
        guess_code = 4'hA;
        applyStimulus();
        checkOutput("t2_open", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        applyStimulus();
        checkOutput("t2_relock", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);

        $display("[TB] step 3: three wrong guesses");
        guess_code = 4'h5;
        applyStimulus();
        checkOutput("t3_wrong1", 1'b0, 1'b0, 1'b1, 1'b1, LOCK_EN ? 2'd2 : 2'd3);
        tick(1);
        checkOutput("t3_wrong_drop", 1'b0, 1'b0, 1'b0, 1'b1, LOCK_EN ? 2'd2 : 2'd3);
        applyStimulus();
        checkOutput("t3_wrong2", 1'b0, 1'b0, 1'b1, 1'b1, LOCK_EN ? 2'd1 : 2'd3);
        applyStimulus();
        checkOutput("t3_wrong3", 1'b0, LOCK_EN, 1'b1, ~LOCK_EN, LOCK_EN ? 2'd0 : 2'd3);

`ifdef PWCHK_LOCKOUT_EN
        $display("[TB] step 4: correct guess during lockout is ignored");
        guess_code = 4'hA;
        applyStimulus();
        checkOutput("t4_lock_ignore", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(4);
        checkOutput("t4_lock_last", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(1);
        checkOutput("t4_lock_exit", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
`endif

        $display("[TB] step 4b: held enter gives one event");
        guess_code = 4'hA;
        applyStimulus();
        checkOutput("t4_open", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        enter = 1'b1;
        tick(20);
        checkOutput("t4_hold", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        enter = 1'b0;
        tick(5);
        checkOutput("t4_release", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);

        $display("[TB] step 5: SET while armed and dual enables are ignored");
        guess_en = 1'b0;
        set_en   = 1'b1;
        set_code = 4'h3;
        applyStimulus();
        checkOutput("t5_set_ignored", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        set_en     = 1'b0;
        guess_en   = 1'b1;
        guess_code = 4'h3;
        applyStimulus();
        checkOutput("t5_new_code_wrong", 1'b0, 1'b0, 1'b1, 1'b1, LOCK_EN ? 2'd2 : 2'd3);
        guess_code = 4'hA;
        applyStimulus();
        checkOutput("t5_old_code_opens", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        set_en = 1'b1;
        applyStimulus();
        checkOutput("t5_both_en", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        set_en = 1'b0;
        applyStimulus();
        checkOutput("t5_relock", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);

        $display("[TB] step 6: reset after three wrong guesses");
        guess_code = 4'h5;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus();
        end
        checkOutput("t6_third_wrong", 1'b0, LOCK_EN, 1'b1, ~LOCK_EN, LOCK_EN ? 2'd0 : 2'd3);
        tick(2);
        reset = 1'b1;
        tick(1);
        checkOutput("t6_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        reset      = 1'b0;
        guess_code = 4'h0;
        applyStimulus();
        checkOutput("t6_idle_guess", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
